icache_refill_ctrl: RTL
=======================

// Module: icache_refill_ctrl
// PURPOSE
//  Miss-side refill engine for the instruction cache core. On a fetch miss it stalls the pipeline.
//  It reads one cache line from memory one word at a time over a req/ack handshake.
//  It packs the words into a line image and writes that image into the cache core with a single bwrite pulse.
//  Sits between the fetch stage, the cache core (hit / bwrite / block_in / address) and main memory.
// PARAMETERS
//  asize  32                 address width
//  dsize  32                 memory word width
//  bbits  5                  line offset bits (32-byte line)
//  bsize  8<<bbits (256)     line width in bits
//  WORDS  bsize/dsize (8)    words per line
//  CBITS  3                  log2(WORDS), word counter width
// PORTS
//  CLK         in   1      clock, all state on posedge
//  RESET       in   1      synchronous, active-low
//  SYS         in   1      cache flush/abort, synchronous, active-high
//  fetch_req   in   1      fetch stage wants the instruction at fetch_addr
//  fetch_addr  in   asize  fetch byte address
//  hit         in   1      cache core hit for core_addr
//  core_addr   out  asize  address driven to cache core
//  bwrite      out  1      one-cycle line write strobe to cache core
//  block_out   out  bsize  assembled line, to core block_in
//  stall       out  1      hold the fetch stage
//  mem_req     out  1      memory read request
//  mem_addr    out  asize  word-aligned memory read address
//  mem_ack     in   1      memory data valid; consumed only while mem_req=1
//  mem_data    in   dsize  memory read data
//  miss_count  out  16     saturating refill counter
// BEHAVIOUR
//  Reset (RESET=0 at posedge):
//   - state=IDLE; mem_req=0; bwrite=0; block_out=0; miss_count=0; word counter=0.
//  SYS=1 at posedge (RESET=1):
//   - Same as reset, except miss_count is held.
//   - Any in-flight fill is abandoned; no bwrite is issued.
//   - A mem_ack arriving in that cycle is dropped.
//  core_addr:
//   - IDLE: core_addr = fetch_addr.
//   - Otherwise: core_addr = latched miss_addr.
//  stall (combinational):
//   - stall = (state!=IDLE) | (state==IDLE & fetch_req & ~hit).
//  FSM:
//   - IDLE:
//     - On fetch_req & ~hit: latch miss_addr=fetch_addr; set cnt = start word; increment miss_count (saturates at 16'hFFFF).
//     - Then go to FILL.
//     - fetch_req & hit: remain in IDLE; no memory traffic.
//   - FILL:
//     - mem_req=1; mem_addr = {miss_addr[asize-1:bbits], word, 2'b00}.
//     - word = (start+cnt) mod WORDS (wraps). Without the optional feature, start=0, so word=cnt.
//     - mem_req and mem_addr stay stable until mem_ack is sampled high.
//     - On ack: mem_data is written into slot word. Slot w occupies bits [bsize-1-w*dsize -: dsize], so word 0 is the MSBs.
//     - cnt increments on each ack; after the WORDS-th ack, go to WRITE.
//     - mem_req falls in the cycle after the last ack.
//   - WRITE:
//     - bwrite=1 for exactly one cycle; block_out is stable; core_addr = miss_addr.
//     - Go to DONE.
//   - DONE:
//     - stall stays 1 for one cycle so the core hit can resolve.
//     - Go to IDLE; block_out is held.
//  Latency:
//   - With mem_ack tied high, a miss gives stall = 1 + WORDS + 2 cycles, i.e. 11 cycles.
//   - The first mem_req is in the cycle after the miss is detected.
//  mem_ack outside FILL is ignored. fetch_addr/fetch_req changes during a fill are ignored.
//  Precedence when simultaneous: RESET > SYS > ack.
// CONFIGURATION
//  CRITICAL_WORD_FIRST_EN defined:
//   - start = miss_addr[bbits-1:2].
//   - The first request is the missed word; subsequent words wrap modulo WORDS.
//   - The slot placement rule and bwrite timing are unchanged.
//  Undefined: start = 0, linear fill of word 0..WORDS-1.
// TESTING
//  1. Miss at 0x0000_1044, ack every cycle, mem_data=0xA0+i:
//     -> mem_addr 0x1040..0x105C in order; one bwrite after the 8th ack.
//     -> block_out[255:224]=0xA0 and [31:0]=0xA7; miss_count=1.
//  2. Same miss with mem_ack delayed 3 cycles per word
//     -> mem_req/mem_addr held constant while waiting; stall held; bwrite once.
//  3. SYS pulsed after the 4th ack
//     -> IDLE next cycle, mem_req=0, no bwrite, stall=0 if hit=1, miss_count unchanged.
//  4. fetch_req with hit=1 for 10 cycles -> mem_req never set, stall=0, miss_count=0.
//  5. CRITICAL_WORD_FIRST_EN, miss at 0x1044:
//     -> mem_addr sequence 0x1044, 0x1048, ..., 0x105C, 0x1040.
//     -> Word from 0x1040 lands in [255:224].
//  6. RESET low mid-FILL -> next cycle all outputs 0, miss_count=0, state=IDLE.

Source files
------------

// File: rtl/icache_refill_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : icache_refill_ctrl_if
// Description : Fetch, cache-core and memory-side signals of the I-cache refill
//               engine. The master modport is the refill controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface icache_refill_ctrl_if #(
    parameter int ASIZE = 32,
    parameter int DSIZE = 32,
    parameter int BBITS = 5
);
    localparam int c_BSIZE = 8 << BBITS;

    logic               fetch_req;
    logic [ASIZE-1:0]   fetch_addr;
    logic               hit;
    logic [ASIZE-1:0]   core_addr;
    logic               bwrite;
    logic [c_BSIZE-1:0] block_out;
    logic               stall;
    logic               mem_req;
    logic [ASIZE-1:0]   mem_addr;
    logic               mem_ack;
    logic [DSIZE-1:0]   mem_data;
    logic [15:0]        miss_count;

    modport master (
        input  fetch_req, fetch_addr, hit, mem_ack, mem_data,
        output core_addr, bwrite, block_out, stall, mem_req, mem_addr, miss_count
    );

    modport slave (
        output fetch_req, fetch_addr, hit, mem_ack, mem_data,
        input  core_addr, bwrite, block_out, stall, mem_req, mem_addr, miss_count
    );
endinterface
`default_nettype wire

// File: rtl/icache_refill_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : icache_refill_ctrl
// Description : I-cache miss refill engine: stalls fetch, reads one line word by
//               word over req/ack, writes it to the core with one bwrite pulse.
//               Optional macro CRITICAL_WORD_FIRST_EN starts at the missed word.
// Revision    : 1.0 - initial release
// ============================================================================
module icache_refill_ctrl #(
    parameter int ASIZE = 32,
    parameter int DSIZE = 32,
    parameter int BBITS = 5
) (
    input  wire logic           CLK,
    input  wire logic           RESET,
    input  wire logic           SYS,
    icache_refill_ctrl_if.master bus
);
    localparam int c_BSIZE = 8 << BBITS;
    localparam int c_WORDS = c_BSIZE / DSIZE;
    localparam int c_CBITS = $clog2(c_WORDS);
    localparam logic [c_CBITS-1:0] c_LAST = c_CBITS'(c_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [ASIZE-1:0]     r_miss_addr;
    logic [c_CBITS-1:0]   r_cnt;
    logic [c_CBITS-1:0]   r_start;
    logic [c_CBITS-1:0]   w_start;
    logic [c_CBITS-1:0]   w_word;
    logic [c_BSIZE-1:0]   r_block;
    logic [15:0]          r_miss_count;
    logic                 w_miss;
    logic                 w_ack;
    logic                 w_mem_req;
    logic                 w_bwrite;
    logic                 w_stall;
    logic [ASIZE-1:0]     w_core_addr;

    assign w_miss = (r_state == IDLE) & bus.fetch_req & ~bus.hit;
    assign w_ack  = (r_state == FILL) & bus.mem_ack;
    assign w_word = r_start + r_cnt;

`ifdef CRITICAL_WORD_FIRST_EN
    assign w_start = bus.fetch_addr[BBITS-1:2];
`else
    assign w_start = '0;
`endif

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_state <= IDLE;
        end else if (SYS) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_mem_req   = 1'b0;
        w_bwrite    = 1'b0;
        w_stall     = 1'b1;
        w_core_addr = r_miss_addr;
        case (r_state)
            IDLE: begin
                w_core_addr = bus.fetch_addr;
                w_stall     = w_miss;
                if (w_miss) begin
                    w_state_nxt = FILL;
                end
            end
            FILL: begin
                w_mem_req = 1'b1;
                if (w_ack && (r_cnt == c_LAST)) begin
                    w_state_nxt = WRITE;
                end
            end
            WRITE: begin
                w_bwrite    = 1'b1;
                w_state_nxt = DONE;
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Word 0 of the line sits in the most significant slot of the image.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_miss_addr  <= '0;
            r_cnt        <= '0;
            r_start      <= '0;
            r_block      <= '0;
            r_miss_count <= '0;
        end else if (SYS) begin
            r_miss_addr  <= '0;
            r_cnt        <= '0;
            r_start      <= '0;
            r_block      <= '0;
        end else begin
            if (w_miss) begin
                r_miss_addr <= bus.fetch_addr;
                r_cnt       <= '0;
                r_start     <= w_start;
                if (r_miss_count != 16'hFFFF) begin
                    r_miss_count <= r_miss_count + 16'd1;
                end
            end
            if (w_ack) begin
                r_cnt <= r_cnt + 1'b1;
                for (int w = 0; w < c_WORDS; w++) begin
                    if (w_word == c_CBITS'(w)) begin
                        r_block[c_BSIZE-1-w*DSIZE -: DSIZE] <= bus.mem_data;
                    end
                end
            end
        end
    end

    assign bus.core_addr  = w_core_addr;
    assign bus.bwrite     = w_bwrite;
    assign bus.block_out  = r_block;
    assign bus.stall      = w_stall;
    assign bus.mem_req    = w_mem_req;
    assign bus.mem_addr   = {r_miss_addr[ASIZE-1:BBITS], w_word, 2'b00};
    assign bus.miss_count = r_miss_count;

endmodule
`default_nettype wire
